// File: rtl/ysyx_23060203_mem_resp.sv
// Memory-side responder for the EXU load/store port: word SRAM with byte strobes and
// programmable latency. Define YSYX_23060203_MEM_RAND_DELAY_EN for LFSR-driven extra latency.
module ysyx_23060203_mem_resp #(
   parameter logic [31:0] BASE  = 32'h8000_0000,
   parameter int unsigned DEPTH = 4096,
   parameter int unsigned LAT   = 2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [2:0]  req_func,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned CW   = $clog2(LAT + 4) + 1;
   localparam logic [31:0] SPAN = 32'(DEPTH) << 2;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d, cnt_init;
   logic           wen_q;
   logic [2:0]     func_q;
   logic [31:0]    addr_q, wdata_q;
   logic [31:0]    rdata_q, rdata_d;
   logic           err_q, err_d;
   logic           latch_en, do_acc;

   logic [31:0] mem [DEPTH];

`ifdef YSYX_23060203_MEM_RAND_DELAY_EN
   logic [15:0] lfsr_q;
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) lfsr_q <= 16'hACE1;
      else       lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end
   assign cnt_init = CW'(LAT) + CW'(lfsr_q[1:0]);
`else
   assign cnt_init = CW'(LAT);
`endif

   // Zero-latency accesses happen on the acceptance edge, so decode from the live request.
   logic        acc_wen;
   logic [2:0]  acc_func;
   logic [31:0] acc_addr, acc_wdata, acc_off;
   assign acc_wen   = (state_q == IDLE) ? req_wen   : wen_q;
   assign acc_func  = (state_q == IDLE) ? req_func  : func_q;
   assign acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
   assign acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
   assign acc_off   = acc_addr - BASE;

   logic          func_ok, mis, range_ok, acc_err;
   logic [AW-1:0] idx;
   logic [31:0]   rd_word, wr_word;
   logic [3:0]    strb;
   logic [7:0]    rd_byte;
   logic [15:0]   rd_half;

   always_comb begin
      if (acc_wen) func_ok = (acc_func == 3'b000) || (acc_func == 3'b001) || (acc_func == 3'b010);
      else         func_ok = (acc_func == 3'b000) || (acc_func == 3'b001) || (acc_func == 3'b010)
                          || (acc_func == 3'b100) || (acc_func == 3'b101);
      mis      = ((acc_func[1:0] == 2'b01) && acc_addr[0])
              || ((acc_func[1:0] == 2'b10) && (acc_addr[1:0] != 2'b00));
      range_ok = (acc_addr >= BASE) && (acc_off < SPAN);
      acc_err  = !func_ok || mis || !range_ok;
   end

   assign idx     = acc_off[AW+1:2];
   assign rd_word = mem[idx];
   assign rd_byte = rd_word[8*acc_addr[1:0] +: 8];
   assign rd_half = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];

   always_comb begin
      strb    = 4'b1111;
      wr_word = acc_wdata;
      rdata_d = '0;
      case (acc_func[1:0])
         2'b00: begin
            strb    = 4'b0001 << acc_addr[1:0];
            wr_word = {4{acc_wdata[7:0]}};
            rdata_d = acc_func[2] ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
         end
         2'b01: begin
            strb    = 4'b0011 << acc_addr[1:0];
            wr_word = {2{acc_wdata[15:0]}};
            rdata_d = acc_func[2] ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
         end
         default: rdata_d = rd_word;
      endcase
      if (acc_wen || acc_err) rdata_d = '0;
      err_d = acc_err;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      latch_en = 1'b0;
      do_acc   = 1'b0;
      case (state_q)
         IDLE: if (req_valid) begin
            latch_en = 1'b1;
            if (cnt_init == '0) begin
               do_acc  = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d   = cnt_init;
               state_d = WAIT;
            end
         end
         WAIT: if (cnt_q == CW'(1)) begin
            do_acc  = 1'b1;
            cnt_d   = '0;
            state_d = RESP;
         end else begin
            cnt_d = cnt_q - CW'(1);
         end
         RESP: if (resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wen_q   <= 1'b0;
         func_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (latch_en) begin
            wen_q   <= req_wen;
            func_q  <= req_func;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
         if (do_acc) begin
            rdata_q <= rdata_d;
            err_q   <= err_d;
         end
      end
   end

   // Array is not reset; rstn gate keeps a held-in-reset request from writing.
   always_ff @(posedge clk) begin
      if (rstn && do_acc && acc_wen && !acc_err) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (strb[i]) mem[idx][8*i +: 8] <= wr_word[8*i +: 8];
         end
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule

// File: tb/tb_ysyx_23060203_mem_resp.sv
// Directed bench for ysyx_23060203_mem_resp: a LAT=2 instance driven by a vector table
// plus hand sequences, and a LAT=0 instance for the zero-wait path.
module tb_ysyx_23060203_mem_resp;

   typedef struct {
      logic        wen;
      logic [2:0]  func;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } t_vec;

   logic        clk = 1'b0;
   logic        rstn;
   logic        rv2, rv0;
   logic        wen;
   logic [2:0]  func;
   logic [31:0] addr, wdata;
   logic        resp_ready;
   logic        rr2, vv2, er2, rr0, vv0, er0;
   logic [31:0] rd2, rd0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ysyx_23060203_mem_resp #(.BASE(32'h8000_0000), .DEPTH(4096), .LAT(2)) u_dut (
      .clk(clk), .rstn(rstn), .req_valid(rv2), .req_ready(rr2), .req_wen(wen),
      .req_func(func), .req_addr(addr), .req_wdata(wdata), .resp_valid(vv2),
      .resp_ready(resp_ready), .resp_rdata(rd2), .resp_err(er2));

   ysyx_23060203_mem_resp #(.BASE(32'h8000_0000), .DEPTH(4096), .LAT(0)) u_dut0 (
      .clk(clk), .rstn(rstn), .req_valid(rv0), .req_ready(rr0), .req_wen(wen),
      .req_func(func), .req_addr(addr), .req_wdata(wdata), .resp_valid(vv0),
      .resp_ready(resp_ready), .resp_rdata(rd0), .resp_err(er0));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic t_vec mk(input logic w, input logic [2:0] f, input logic [31:0] a,
                               input logic [31:0] d, input logic [31:0] r, input logic e);
      t_vec v;
      v.wen = w; v.func = f; v.addr = a; v.wdata = d; v.exp_rdata = r; v.exp_err = e;
      return v;
   endfunction

   // Latency = rising edges after the acceptance edge until resp_valid is seen.
   task automatic do_req(input bit sel0, input t_vec v, input int exp_lat, input string tag);
      int lat;
      @(negedge clk);
      wen = v.wen; func = v.func; addr = v.addr; wdata = v.wdata;
      chk({tag, "_req_ready"}, {31'h0, sel0 ? rr0 : rr2}, 32'h1);
      if (sel0) rv0 = 1'b1; else rv2 = 1'b1;
      @(posedge clk); #1;
      rv0 = 1'b0; rv2 = 1'b0;
      lat = 0;
      while (!(sel0 ? vv0 : vv2) && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_rdata"}, sel0 ? rd0 : rd2, v.exp_rdata);
      chk({tag, "_err"}, {31'h0, sel0 ? er0 : er2}, {31'h0, v.exp_err});
      @(posedge clk); #1;
   endtask

   t_vec vecs [23];
   logic [31:0] held;

   initial begin
      vecs[0]  = mk(1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0,         0);
      vecs[1]  = mk(0, 3'b010, 32'h8000_0004, 32'h0,         32'hDEAD_BEEF, 0);
      vecs[2]  = mk(0, 3'b000, 32'h8000_0007, 32'h0,         32'hFFFF_FFDE, 0);
      vecs[3]  = mk(0, 3'b100, 32'h8000_0007, 32'h0,         32'h0000_00DE, 0);
      vecs[4]  = mk(0, 3'b001, 32'h8000_0006, 32'h0,         32'hFFFF_DEAD, 0);
      vecs[5]  = mk(0, 3'b101, 32'h8000_0004, 32'h0,         32'h0000_BEEF, 0);
      vecs[6]  = mk(1, 3'b000, 32'h8000_0005, 32'h0000_0011, 32'h0,         0);
      vecs[7]  = mk(0, 3'b010, 32'h8000_0004, 32'h0,         32'hDEAD_11EF, 0);
      vecs[8]  = mk(1, 3'b001, 32'h8000_0006, 32'h0000_1234, 32'h0,         0);
      vecs[9]  = mk(0, 3'b010, 32'h8000_0004, 32'h0,         32'h1234_11EF, 0);
      vecs[10] = mk(0, 3'b010, 32'h8000_0002, 32'h0,         32'h0,         1);
      vecs[11] = mk(1, 3'b001, 32'h8000_0001, 32'h0000_FFFF, 32'h0,         1);
      vecs[12] = mk(0, 3'b010, 32'h8000_0004, 32'h0,         32'h1234_11EF, 0);
      vecs[13] = mk(0, 3'b011, 32'h8000_0004, 32'h0,         32'h0,         1);
      vecs[14] = mk(0, 3'b010, 32'h7FFF_FFFC, 32'h0,         32'h0,         1);
      vecs[15] = mk(0, 3'b010, 32'h8000_4000, 32'h0,         32'h0,         1);
      vecs[16] = mk(1, 3'b010, 32'h8000_3FFC, 32'h0A0B_0C0D, 32'h0,         0);
      vecs[17] = mk(0, 3'b010, 32'h8000_3FFC, 32'h0,         32'h0A0B_0C0D, 0);
      vecs[18] = mk(1, 3'b011, 32'h8000_0004, 32'h5555_5555, 32'h0,         1);
      vecs[19] = mk(0, 3'b001, 32'h8000_0005, 32'h0,         32'h0,         1);
      vecs[20] = mk(0, 3'b000, 32'h8000_0004, 32'h0,         32'hFFFF_FFEF, 0);
      vecs[21] = mk(1, 3'b010, 32'h8000_0010, 32'h1122_3344, 32'h0,         0);
      vecs[22] = mk(0, 3'b010, 32'h8000_0010, 32'h0,         32'h1122_3344, 0);

      rstn = 1'b0; rv2 = 1'b0; rv0 = 1'b0; wen = 1'b0; func = '0; addr = '0; wdata = '0;
      resp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", {31'h0, rr2}, 32'h1);
      chk("rst_resp_valid", {31'h0, vv2}, 32'h0);
      chk("rst_rdata", rd2, 32'h0);
      chk("rst_err", {31'h0, er2}, 32'h0);
      @(negedge clk);
      rstn = 1'b1;

      for (int i = 0; i < 23; i++) do_req(1'b0, vecs[i], 2, $sformatf("v%0d", i));

      // Backpressure: response held 5 cycles, stray request must be ignored.
      @(negedge clk);
      wen = 1'b0; func = 3'b010; addr = 32'h8000_0004; resp_ready = 1'b0; rv2 = 1'b1;
      @(posedge clk); #1;
      wen = 1'b1; wdata = 32'h0; held = '0;
      for (int n = 0; n < 20 && !vv2; n++) begin
         @(posedge clk); #1;
      end
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         chk($sformatf("bp%0d_valid", n), {31'h0, vv2}, 32'h1);
         chk($sformatf("bp%0d_rdata", n), rd2, 32'h1234_11EF);
         chk($sformatf("bp%0d_err", n), {31'h0, er2}, 32'h0);
         chk($sformatf("bp%0d_req_ready", n), {31'h0, rr2}, 32'h0);
      end
      rv2 = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_valid", {31'h0, vv2}, 32'h0);
      chk("bp_release_req_ready", {31'h0, rr2}, 32'h1);
      do_req(1'b0, vecs[12], 2, "bp_after");

      // Reset during WAIT of a store: store dropped, outputs cleared at once.
      @(negedge clk);
      wen = 1'b1; func = 3'b010; addr = 32'h8000_0010; wdata = 32'hFFFF_FFFF; rv2 = 1'b1;
      @(posedge clk); #1;
      rv2 = 1'b0;
      chk("wait_req_ready", {31'h0, rr2}, 32'h0);
      #2 rstn = 1'b0;
      #1;
      chk("midrst_valid", {31'h0, vv2}, 32'h0);
      chk("midrst_req_ready", {31'h0, rr2}, 32'h1);
      chk("midrst_rdata", rd2, 32'h0);
      chk("midrst_err", {31'h0, er2}, 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      do_req(1'b0, vecs[22], 2, "after_rst");

      // Zero-latency instance.
      do_req(1'b1, mk(1, 3'b010, 32'h8000_0020, 32'hCAFE_F00D, 32'h0, 0), 0, "l0_sw");
      do_req(1'b1, mk(0, 3'b010, 32'h8000_0020, 32'h0, 32'hCAFE_F00D, 0), 0, "l0_lw");
      do_req(1'b1, mk(0, 3'b000, 32'h8000_0023, 32'h0, 32'hFFFF_FFCA, 0), 0, "l0_lb");
      do_req(1'b1, mk(0, 3'b010, 32'h8000_0021, 32'h0, 32'h0, 1), 0, "l0_mis");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

endmodule

// File: doc/ysyx_23060203_mem_resp.md
Name: ysyx_23060203_mem_resp

Overview:
Memory-side responder for the execute stage's load/store request interface; the other end of the EXU memory port.
- Accepts one load or store per valid/ready handshake and decodes funct3 exactly as the EXU issues it.
- Performs byte-lane alignment, strobed writes and sign/zero extension against an internal word-wide SRAM.
- Returns load data or store completion after a programmable latency, with an error flag for bad accesses.

Parameters:
BASE, 32'h8000_0000, byte address of word 0 of the array
DEPTH, 4096, array size in 32-bit words (power of two)
LAT, 2, wait cycles between acceptance and the access; 0 allowed

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  responder can accept
req_wen  in  1  1 = store, 0 = load
req_func  in  3  funct3 of the load/store
req_addr  in  32  byte address
req_wdata  in  32  store data, in low bits
resp_valid  out  1  response present
resp_ready  in  1  consumer takes response
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  misaligned, out-of-range or illegal funct

Behaviour:
- States: IDLE, WAIT, RESP.
- req_ready = (state==IDLE). Acceptance happens when req_valid & req_ready at a rising edge.
- On acceptance, latch wen, func, addr and wdata; load cnt=LAT.
  - LAT==0: go directly to RESP.
  - Otherwise go to WAIT.
- WAIT: decrement cnt each cycle. On the edge where cnt==1, perform the access and enter RESP.
- Total latency is acceptance edge + LAT edges to resp_valid=1. At LAT=0, resp_valid rises one cycle after acceptance.
- Access (same edge as the RESP entry):
  - Register resp_rdata and resp_err.
  - For a legal store, write the array on this edge using byte strobes.
- RESP: hold resp_valid, resp_rdata and resp_err stable until resp_valid & resp_ready; then go to IDLE.
  - resp_valid drops next cycle.
  - A new request cannot be accepted in that same cycle.
- Load funct: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Anything else is illegal.
- Store funct: 000 SB, 001 SH, 010 SW. Anything else is illegal.
- Index = (addr-BASE)>>2. Out-of-range if addr<BASE or index>=DEPTH.
- Misaligned:
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=0.
- On error: resp_err=1, resp_rdata=0, no array write.
- Load extraction:
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Store strobes:
  - SB: 4'b0001<<addr[1:0], data replicated per byte.
  - SH: 4'b0011<<addr[1:0], data replicated per halfword.
  - SW: 4'b1111.
- Reset (async assert, sync deassert on next clk):
  - state=IDLE, cnt=0, resp_valid=0, resp_rdata=0, resp_err=0.
  - req_ready=1 while in IDLE, including during reset.
  - Array contents are not reset.
- Reset mid-WAIT or mid-RESP: the request is dropped and a pending store is not written.
- req_* inputs are ignored outside IDLE. resp_ready is ignored outside RESP.

Optional Feature:
Macro YSYX_23060203_MEM_RAND_DELAY_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1) advances every clock.
  - On acceptance, cnt loads LAT + lfsr[1:0], giving extra latency of 0-3 cycles for stress testing.
  - All functional results are unchanged.
- Undefined: latency is exactly LAT; no LFSR logic is present.

Test Plan:
- Reset, LAT=2; SW addr 8000_0004 data DEADBEEF, resp_ready=1 -> resp_valid at acceptance+2 edges, err=0, rdata=0. Then LW 8000_0004 -> rdata DEADBEEF.
- With word DEADBEEF at 8000_0004 (EXU byte-read order):
  - LB 8000_0007 -> FFFF_FFDE.
  - LBU 8000_0007 -> 0000_00DE.
  - LH 8000_0006 -> FFFF_DEAD.
  - LHU 8000_0004 -> 0000_BEEF.
- SB 8000_0005 data 0000_0011, then LW 8000_0004 -> DEAD11EF. SH 8000_0006 data 0000_1234, then LW -> 123411EF.
- Errors:
  - LW 8000_0002 -> err=1, rdata=0.
  - SH 8000_0001 -> err=1 and a following LW shows the word unchanged.
  - Load funct 011 -> err=1.
  - Address 7FFF_FFFC -> err=1.
  - Address BASE+4*DEPTH -> err=1.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid, rdata and err stable and req_ready=0 throughout. Release -> IDLE next cycle, req_ready=1.
- Reset asserted during WAIT of an SW to 8000_0010 -> outputs reset immediately. Subsequent LW 8000_0010 returns the prior contents. LAT=0 build: resp_valid rises one cycle after acceptance.
